// File: rtl/ram_arbiter.sv
//------------------------------------------------------------------------------
// Module : ram_arbiter
// Shares one synchronous RAM port between the CPU and a debug/loader port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_nReset,
    input  logic              i_cpuReq,
    input  logic              i_cpuWe,
    input  logic [ADDR_W-1:0] i_cpuAddr,
    input  logic [DATA_W-1:0] i_cpuWData,
    output logic              o_cpuGnt,
    output logic              o_cpuStall,
    output logic [DATA_W-1:0] o_cpuRData,
    output logic              o_cpuValid,
    input  logic              i_dbgReq,
    input  logic              i_dbgWe,
    input  logic              i_dbgLock,
    input  logic [ADDR_W-1:0] i_dbgAddr,
    input  logic [DATA_W-1:0] i_dbgWData,
    output logic              o_dbgGnt,
    output logic [DATA_W-1:0] o_dbgRData,
    output logic              o_dbgValid,
    output logic              o_ramEn,
    output logic              o_ramWe,
    output logic [ADDR_W-1:0] o_ramAddr,
    output logic [DATA_W-1:0] o_ramWData,
    input  logic [DATA_W-1:0] i_ramRData
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(BURST_MAX + 1);
    localparam logic [WAIT_W-1:0]  C_WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] C_BURST_MAX = BURST_W'(BURST_MAX);

    typedef enum logic [0:0] {
        S_NORMAL   = 1'b0,
        S_DBG_LOCK = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [WAIT_W-1:0]    r_waitCnt;
    logic [WAIT_W-1:0]    w_nextWait;
    logic [BURST_W-1:0]   r_burstCnt;
    logic [BURST_W-1:0]   w_nextBurst;
    logic                 r_cpuValid;
    logic                 r_dbgValid;
    logic                 w_cpuGnt;
    logic                 w_dbgGnt;

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_state    <= S_NORMAL;
            r_waitCnt  <= '0;
            r_burstCnt <= '0;
            r_cpuValid <= 1'b0;
            r_dbgValid <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_waitCnt  <= w_nextWait;
            r_burstCnt <= w_nextBurst;
            r_cpuValid <= w_cpuGnt & ~i_cpuWe;
            r_dbgValid <= w_dbgGnt & ~i_dbgWe;
        end
    end

    always_comb begin
        w_cpuGnt    = 1'b0;
        w_dbgGnt    = 1'b0;
        w_nextState = r_state;
        w_nextWait  = r_waitCnt;
        w_nextBurst = r_burstCnt;
        case (r_state)
            S_NORMAL: begin
                if (i_dbgReq && (!i_cpuReq || (r_waitCnt == C_WAIT_MAX))) begin
                    w_dbgGnt   = 1'b1;
                    w_nextWait = '0;
                    if (i_dbgLock) begin
                        w_nextState = S_DBG_LOCK;
                        w_nextBurst = BURST_W'(1);
                    end
                end else begin
                    w_cpuGnt = i_cpuReq;
                    if (!i_dbgReq) begin
                        w_nextWait = '0;
                    end else if (r_waitCnt != C_WAIT_MAX) begin
                        w_nextWait = r_waitCnt + WAIT_W'(1);
                    end
                end
            end
            S_DBG_LOCK: begin
                if (!(i_dbgReq && i_dbgLock)) begin
                    // Release costs one idle turnaround cycle.
                    w_nextState = S_NORMAL;
                    w_nextBurst = '0;
                    w_nextWait  = '0;
                end else if ((r_burstCnt == C_BURST_MAX) && i_cpuReq) begin
                    // Forced CPU slot; dbg is first in line afterwards.
                    w_cpuGnt    = 1'b1;
                    w_nextState = S_NORMAL;
                    w_nextBurst = '0;
                    w_nextWait  = C_WAIT_MAX;
                end else begin
                    w_dbgGnt = 1'b1;
                    if (r_burstCnt != C_BURST_MAX) begin
                        w_nextBurst = r_burstCnt + BURST_W'(1);
                    end
                end
            end
            default: begin
                w_nextState = S_NORMAL;
            end
        endcase
    end

    assign o_cpuGnt   = w_cpuGnt;
    assign o_dbgGnt   = w_dbgGnt;
    assign o_cpuStall = i_cpuReq & ~w_cpuGnt;
    assign o_cpuValid = r_cpuValid;
    assign o_dbgValid = r_dbgValid;
    assign o_cpuRData = i_ramRData;
    assign o_dbgRData = i_ramRData;

    assign o_ramEn    = w_cpuGnt | w_dbgGnt;
    assign o_ramWe    = w_cpuGnt ? i_cpuWe    : (w_dbgGnt ? i_dbgWe    : 1'b0);
    assign o_ramAddr  = w_cpuGnt ? i_cpuAddr  : (w_dbgGnt ? i_dbgAddr  : '0);
    assign o_ramWData = w_cpuGnt ? i_cpuWData : (w_dbgGnt ? i_dbgWData : '0);

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_ram_arbiter
// Vector-driven bench for ram_arbiter with a behavioural RAM and read scoreboards.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_arbiter;

    logic        clk;
    logic        nReset;
    logic        cpuReq, cpuWe, dbgReq, dbgWe, dbgLock;
    logic [15:0] cpuAddr, cpuWData, dbgAddr, dbgWData;
    logic        cpuGnt, cpuStall, cpuValid, dbgGnt, dbgValid;
    logic [15:0] cpuRData, dbgRData;
    logic        ramEn, ramWe;
    logic [15:0] ramAddr, ramWData, ramRData;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] cpu_q[$];
    logic [15:0] dbg_q[$];
    logic [15:0] mem [0:65535];

    typedef struct {
        logic        cReq, cWe;
        logic [15:0] cAddr, cWd;
        logic        dReq, dWe, dLock;
        logic [15:0] dAddr, dWd;
        logic        eC, eD;
        logic [15:0] eCD, eDD;
    } vec_t;

    vec_t vecsA[$];
    vec_t vecsB[$];

    ram_arbiter dut (
        .i_clk      (clk),
        .i_nReset   (nReset),
        .i_cpuReq   (cpuReq),
        .i_cpuWe    (cpuWe),
        .i_cpuAddr  (cpuAddr),
        .i_cpuWData (cpuWData),
        .o_cpuGnt   (cpuGnt),
        .o_cpuStall (cpuStall),
        .o_cpuRData (cpuRData),
        .o_cpuValid (cpuValid),
        .i_dbgReq   (dbgReq),
        .i_dbgWe    (dbgWe),
        .i_dbgLock  (dbgLock),
        .i_dbgAddr  (dbgAddr),
        .i_dbgWData (dbgWData),
        .o_dbgGnt   (dbgGnt),
        .o_dbgRData (dbgRData),
        .o_dbgValid (dbgValid),
        .o_ramEn    (ramEn),
        .o_ramWe    (ramWe),
        .o_ramAddr  (ramAddr),
        .o_ramWData (ramWData),
        .i_ramRData (ramRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the access.
    initial begin
        mem[16'h0010] = 16'h1234;
        mem[16'h0020] = 16'h5678;
        mem[16'h0100] = 16'h0000;
        ramRData = 16'h0000;
        forever begin
            @(posedge clk);
            if (ramEn) begin
                if (ramWe) mem[ramAddr] = ramWData;
                else       ramRData <= mem[ramAddr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t row(input logic c, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                                 input logic d, input logic dw, input logic dl, input logic [15:0] da,
                                 input logic [15:0] dd, input logic ec, input logic ed,
                                 input logic [15:0] ecd, input logic [15:0] edd);
        vec_t v;
        v.cReq = c;  v.cWe = cw; v.cAddr = ca; v.cWd = cd;
        v.dReq = d;  v.dWe = dw; v.dLock = dl; v.dAddr = da; v.dWd = dd;
        v.eC = ec;   v.eD = ed;  v.eCD = ecd;  v.eDD = edd;
        return v;
    endfunction

    // Read-only row: CPU reads 0x0010 (0x1234), dbg reads 0x0020 (0x5678).
    function automatic vec_t rd(input logic c, input logic d, input logic dl, input logic ec, input logic ed);
        return row(c, 1'b0, 16'h0010, 16'h0, d, 1'b0, dl, 16'h0020, 16'h0, ec, ed, 16'h1234, 16'h5678);
    endfunction

    task automatic check_valid();
        logic [15:0] e;
        chk("cpuValid", cpuValid, cpu_q.size() != 0);
        if (cpu_q.size() != 0) begin
            e = cpu_q.pop_front();
            chk("cpuRData", cpuRData, e);
        end
        chk("dbgValid", dbgValid, dbg_q.size() != 0);
        if (dbg_q.size() != 0) begin
            e = dbg_q.pop_front();
            chk("dbgRData", dbgRData, e);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic apply(input vec_t v);
        logic [15:0] ea, ewd;
        logic        ewe;
        cpuReq = v.cReq; cpuWe = v.cWe; cpuAddr = v.cAddr; cpuWData = v.cWd;
        dbgReq = v.dReq; dbgWe = v.dWe; dbgLock = v.dLock; dbgAddr = v.dAddr; dbgWData = v.dWd;
        ea  = v.eC ? v.cAddr : (v.eD ? v.dAddr : 16'h0);
        ewd = v.eC ? v.cWd   : (v.eD ? v.dWd   : 16'h0);
        ewe = v.eC ? v.cWe   : (v.eD ? v.dWe   : 1'b0);
        @(negedge clk);
        check_valid();
        chk("cpuGnt",   cpuGnt,   v.eC);
        chk("dbgGnt",   dbgGnt,   v.eD);
        chk("cpuStall", cpuStall, v.cReq & ~v.eC);
        chk("ramEn",    ramEn,    v.eC | v.eD);
        chk("ramWe",    ramWe,    ewe);
        chk("ramAddr",  ramAddr,  ea);
        chk("ramWData", ramWData, ewd);
        if (v.eC && !v.cWe) cpu_q.push_back(v.eCD);
        if (v.eD && !v.dWe) dbg_q.push_back(v.eDD);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Idle
        for (int i = 0; i < 10; i++) vecsA.push_back(rd(0, 0, 0, 0, 0));
        // Single CPU read
        vecsA.push_back(rd(1, 0, 0, 1, 0));
        vecsA.push_back(rd(0, 0, 0, 0, 0));
        // Contention without lock: C,C,C,C,D twice
        for (int i = 0; i < 10; i++) vecsA.push_back(rd(1, 1, 0, (i % 5) != 4, (i % 5) == 4));
        vecsA.push_back(rd(0, 0, 0, 0, 0));
        // Locked burst of 12 with CPU waiting: D x8, C, D x4, turnaround, C
        vecsA.push_back(rd(0, 1, 1, 0, 1));
        for (int i = 0; i < 7; i++) vecsA.push_back(rd(1, 1, 1, 0, 1));
        vecsA.push_back(rd(1, 1, 1, 1, 0));
        for (int i = 0; i < 4; i++) vecsA.push_back(rd(1, 1, 1, 0, 1));
        vecsA.push_back(rd(1, 0, 0, 0, 0));
        vecsA.push_back(rd(1, 0, 0, 1, 0));
        vecsA.push_back(rd(0, 0, 0, 0, 0));
        // Saturated burst holds while CPU is idle, then the CPU gets its slot
        for (int i = 0; i < 10; i++) vecsA.push_back(rd(0, 1, 1, 0, 1));
        vecsA.push_back(rd(1, 1, 1, 1, 0));
        vecsA.push_back(rd(0, 0, 0, 0, 0));
        // dbg write then CPU readback
        vecsA.push_back(row(0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h0100, 16'hBEEF, 0, 1, 16'h0, 16'h0));
        vecsA.push_back(row(1, 0, 16'h0100, 16'h0, 0, 0, 0, 16'h0, 16'h0, 1, 0, 16'hBEEF, 16'h0));
        vecsA.push_back(rd(0, 0, 0, 0, 0));
        // After a mid-read reset the wait counter must start from zero
        for (int i = 0; i < 5; i++) vecsB.push_back(rd(1, 1, 0, i != 4, i == 4));
        vecsB.push_back(rd(0, 0, 0, 0, 0));

        nReset = 1'b0;
        cpuReq = 0; cpuWe = 0; cpuAddr = 0; cpuWData = 0;
        dbgReq = 0; dbgWe = 0; dbgLock = 0; dbgAddr = 0; dbgWData = 0;
        #2;
        chk("rst_cpuGnt",   cpuGnt,   1'b0);
        chk("rst_dbgGnt",   dbgGnt,   1'b0);
        chk("rst_ramEn",    ramEn,    1'b0);
        chk("rst_cpuValid", cpuValid, 1'b0);
        chk("rst_dbgValid", dbgValid, 1'b0);
        repeat (2) @(posedge clk);
        #1 nReset = 1'b1;

        foreach (vecsA[i]) apply(vecsA[i]);

        // Reset asserted the cycle after a CPU read grant
        apply(rd(1, 0, 0, 1, 0));
        chk("pre_rst_cpuValid", cpuValid, 1'b1);
        cpuReq = 1'b0;
        nReset = 1'b0;
        #1;
        chk("midrst_cpuValid", cpuValid, 1'b0);
        chk("midrst_dbgValid", dbgValid, 1'b0);
        cpu_q.delete();
        dbg_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("inrst_ramEn", ramEn, 1'b0);
        @(posedge clk);
        #1 nReset = 1'b1;

        foreach (vecsB[i]) apply(vecsB[i]);

        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("dbg_q_empty", dbg_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
